aes_ctr_sched: RTL and testbench
================================

Name: aes_ctr_sched

Overview:
- Round-robin scheduler that shares one aes_ctr_core among NUM_CH independent block streams.
- Each channel owns a key/IV context and a running 128-bit counter. The scheduler grants one channel per packet (until its last block) and reloads the core with that channel's key and current counter via a start pulse.
- Forwards the channel's blocks to the core and returns results tagged with the channel id.
- Sits between the per-channel AXIS adapters and the single aes_ctr_core instance.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- CH_W, 2, width of channel index; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset; the parent drives the core's rst_n = ~rst.
- cfg_we  in  1  context write strobe.
- cfg_ready  out  1  context write accepted when cfg_we & cfg_ready.
- cfg_ch  in  CH_W  channel being configured.
- cfg_key  in  128  channel key.
- cfg_iv  in  128  channel initial counter.
- s_valid  in  NUM_CH  per-channel block valid.
- s_ready  out  NUM_CH  per-channel block ready.
- s_data  in  NUM_CH*128  channel c occupies bits [c*128 +: 128].
- s_keep  in  NUM_CH*16  per-channel tkeep.
- s_last  in  NUM_CH  per-channel packet end.
- m_valid/m_ready  out/in  1  result handshake.
- m_data  out  128  result data.
- m_keep  out  16  result tkeep.
- m_last  out  1  result packet end.
- m_ch  out  CH_W  channel tag.
- core_start  out  1  start pulse to aes_ctr_core.
- core_key  out  128  key to core.
- core_iv  out  128  counter load value to core.
- core_in_valid/core_in_ready  out/in  1  core input handshake.
- core_in_data  out  128.
- core_in_keep  out  16.
- core_in_last  out  1.
- core_out_valid/core_out_ready  in/out  1  core output handshake.
- core_out_data  in  128.
- core_out_keep  in  16.
- core_out_last  in  1.
- busy  out  1  packet in progress.
- grant_ch  out  CH_W  currently granted channel.

Behaviour:
- Per-channel registers: key[c], ctr[c], ctx_vld[c].
- Reset clears all state: ctx_vld, ctr, key, rr_ptr, grant_ch, busy, core_start, and every output go to 0; s_ready = 0; cfg_ready = 1. Reset mid-packet aborts the packet and drops it silently; the core is reset simultaneously.
- Config write: when cfg_we & cfg_ready, set key[cfg_ch] = cfg_key, ctr[cfg_ch] = cfg_iv, ctx_vld[cfg_ch] = 1.
- cfg_ready = !(busy && cfg_ch == grant_ch). Writes to other channels are always accepted. cfg_ch >= NUM_CH is accepted and ignored.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - eligible[c] = s_valid[c] & ctx_vld[c].
  - Pick the first eligible channel searching from rr_ptr upward, with wrap-around.
  - Register the pick in grant_ch, set busy = 1, go to LOAD. No eligible channel: stay in IDLE.
- LOAD: exactly one cycle.
  - core_start = 1, core_iv = ctr[grant_ch].
  - core_in_valid = 0 and all s_ready = 0.
  - Go to RUN.
- RUN:
  - core_in_valid = s_valid[grant_ch], s_ready[grant_ch] = core_in_ready; other s_ready bits = 0.
  - core_in_data/keep/last are the granted channel's slice.
  - Output side: m_valid = core_out_valid, core_out_ready = m_ready, m_data/keep/last = core_out_*, m_ch = grant_ch. This path is combinational and adds no latency.
  - On each output handshake: ctr[grant_ch] += 1, modulo 2^128 (all-ones wraps to 0).
  - Output handshake with core_out_last = 1: rr_ptr = grant_ch + 1 (wraps to 0 at NUM_CH), busy = 0, go to IDLE.
- Outside RUN: m_valid = 0, core_out_ready = 0, core_in_valid = 0.
- core_key = key[grant_ch] at all times. It must stay stable throughout the packet, which is guaranteed by the cfg_ready rule.
- Overhead: 2 cycles per packet (IDLE to first core_in_valid), plus the core's own latency per block.
- A lost or dropped channel valid mid-packet holds RUN indefinitely; there is no timeout.
- Back-to-back packets from the same channel resume from the updated counter, with no reload of cfg_iv.

Test Plan:
- Channel 0 ctx key=2b7e151628aed2a6abf7158809cf4f3c, iv=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff; send 2 blocks 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51 (last on 2nd), keep=ffff -> m_data 874d6191b620e3261bef6864990db6ce then 9806f66b7970fdff8617187bb9fffdff, m_ch=0, m_last on 2nd; ctr[0] ends at iv+2.
- Channels 0..3 all valid with 1-block packets, rr_ptr=0 -> grants in order 0,1,2,3; rerequest all -> 0,1,2,3 again; channel 1 idle -> order 0,2,3.
- Channel 2 valid without a ctx write -> never granted, s_ready[2]=0; after a cfg write it is granted within 2 cycles.
- cfg_we to grant_ch during RUN -> cfg_ready=0 and the context is unchanged; a simultaneous write to another channel is accepted.
- iv=ffffffffffffffffffffffffffffffff, two 1-block packets on the same channel -> the second packet's LOAD drives core_iv=0; second output equals keystream(ctr=0) XOR pt.
- Assert rst during RUN with m_ready=0 -> the next cycle has busy=0, m_valid=0, all ctx_vld=0; after reconfiguring, operation restarts cleanly.

Source files
------------

// File: rtl/aes_ctr_sched.sv
// ---------------------------------------------------------------------------
// aes_ctr_sched
//
// Round-robin scheduler that time-shares one aes_ctr_core between NUM_CH
// independent block streams. Each channel owns a key, a running 128-bit
// counter and a context-valid flag. A channel is granted for a whole packet.
// The core is reloaded with that channel's key and current counter through a
// one-cycle start pulse. The channel's blocks are then forwarded to the core,
// and the results come back tagged with the channel id.
//
// Handshake semantics: every valid/ready pair transfers one beat on a rising
// clk edge where both are high. A source holds its payload stable while
// valid is high and ready is low. Ready may depend combinationally on valid.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_*               per-channel context write (key, initial counter)
//   s_*                 NUM_CH input block streams, channel c at slice c
//   m_*                 tagged result stream (m_ch = producing channel)
//   core_start/key/iv   reload interface of the shared core
//   core_in_*           blocks towards the core
//   core_out_*          results from the core
//   busy, grant_ch      packet in progress / channel owning the core
//   fsm_state           scheduler state (0 idle, 1 load, 2 run)
// ---------------------------------------------------------------------------
module aes_ctr_sched #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [127:0]          cfg_key,
    input  logic [127:0]          cfg_iv,
    input  logic [NUM_CH-1:0]     s_valid,
    output logic [NUM_CH-1:0]     s_ready,
    input  logic [NUM_CH*128-1:0] s_data,
    input  logic [NUM_CH*16-1:0]  s_keep,
    input  logic [NUM_CH-1:0]     s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [127:0]          m_data,
    output logic [15:0]           m_keep,
    output logic                  m_last,
    output logic [CH_W-1:0]       m_ch,
    output logic                  core_start,
    output logic [127:0]          core_key,
    output logic [127:0]          core_iv,
    output logic                  core_in_valid,
    input  logic                  core_in_ready,
    output logic [127:0]          core_in_data,
    output logic [15:0]           core_in_keep,
    output logic                  core_in_last,
    input  logic                  core_out_valid,
    output logic                  core_out_ready,
    input  logic [127:0]          core_out_data,
    input  logic [15:0]           core_out_keep,
    input  logic                  core_out_last,
    output logic                  busy,
    output logic [CH_W-1:0]       grant_ch,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [127:0]      key_r [NUM_CH];
    logic [127:0]      ctr_r [NUM_CH];
    logic [NUM_CH-1:0] ctx_vld;
    logic [CH_W-1:0]   rr_ptr;

    logic [NUM_CH-1:0] eligible;
    logic              pick_found;
    logic [CH_W-1:0]   pick_ch;
    logic [CH_W-1:0]   cand;
    int                cand_int;
    logic              out_hs;
    logic              cfg_hit;
    logic [CH_W-1:0]   rr_nxt;

    // Only channels that both request and hold a context may win.
    assign eligible = s_valid & ctx_vld;

    // First eligible channel at or after rr_ptr, wrapping at NUM_CH.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        cand       = '0;
        cand_int   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_int = int'(rr_ptr) + i;
            if (cand_int >= NUM_CH) begin
                cand_int = cand_int - NUM_CH;
            end
            cand = CH_W'(cand_int);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    assign out_hs  = (state == ST_RUN) && core_out_valid && m_ready;
    assign rr_nxt  = (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + CH_W'(1);

    // Writing the granted channel mid-packet is refused so core_key and the
    // counter being advanced stay coherent for the whole packet.
    assign cfg_ready = !(busy && (cfg_ch == grant_ch));
    assign cfg_hit   = cfg_we && cfg_ready && (int'(cfg_ch) < NUM_CH);

    // State register and per-channel context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ctx_vld  <= '0;
            rr_ptr   <= '0;
            grant_ch <= '0;
            busy     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                key_r[c] <= '0;
                ctr_r[c] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (cfg_hit) begin
                key_r[cfg_ch]   <= cfg_key;
                ctr_r[cfg_ch]   <= cfg_iv;
                ctx_vld[cfg_ch] <= 1'b1;
            end
            if (state == ST_IDLE && pick_found) begin
                grant_ch <= pick_ch;
                busy     <= 1'b1;
            end
            // Counter tracks results delivered, so a following packet on the
            // same channel resumes at the next unused counter value.
            if (out_hs) begin
                ctr_r[grant_ch] <= ctr_r[grant_ch] + 128'd1;
                if (core_out_last) begin
                    rr_ptr <= rr_nxt;
                    busy   <= 1'b0;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_found) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN:  if (out_hs && core_out_last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: all data paths are purely combinational in RUN.
    always_comb begin
        core_start     = 1'b0;
        core_in_valid  = 1'b0;
        core_in_data   = '0;
        core_in_keep   = '0;
        core_in_last   = 1'b0;
        s_ready        = '0;
        m_valid        = 1'b0;
        m_data         = '0;
        m_keep         = '0;
        m_last         = 1'b0;
        core_out_ready = 1'b0;
        case (state)
            ST_LOAD: core_start = 1'b1;
            ST_RUN: begin
                core_in_valid     = s_valid[grant_ch];
                s_ready[grant_ch] = core_in_ready;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (grant_ch == CH_W'(c)) begin
                        core_in_data = s_data[c*128 +: 128];
                        core_in_keep = s_keep[c*16 +: 16];
                        core_in_last = s_last[c];
                    end
                end
                m_valid        = core_out_valid;
                m_data         = core_out_data;
                m_keep         = core_out_keep;
                m_last         = core_out_last;
                core_out_ready = m_ready;
            end
            default: ;
        endcase
    end

    assign core_key  = key_r[grant_ch];
    assign core_iv   = ctr_r[grant_ch];
    assign m_ch      = grant_ch;
    assign fsm_state = state;

endmodule

// File: tb/tb_aes_ctr_sched.sv
// ---------------------------------------------------------------------------
// tb_aes_ctr_sched
//
// Bench for aes_ctr_sched. A small behavioural core sits on the core
// interface. Its keystream is a simple function of key and counter, with
// one cycle of latency. The reference model keeps per-channel queues of
// pending packets plus a round-robin pointer. From these it predicts the
// order of grants, the counter loaded for each packet and every tagged
// result.
// ---------------------------------------------------------------------------
module tb_aes_ctr_sched;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int EXP_W  = CH_W + 16 + 1 + 128;
  localparam int LD_W   = CH_W + 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                  cfg_we, cfg_ready;
  logic [CH_W-1:0]       cfg_ch;
  logic [127:0]          cfg_key, cfg_iv;
  logic [NUM_CH-1:0]     s_valid, s_ready, s_last;
  logic [NUM_CH*128-1:0] s_data;
  logic [NUM_CH*16-1:0]  s_keep;
  logic                  m_valid, m_ready, m_last;
  logic [127:0]          m_data;
  logic [15:0]           m_keep;
  logic [CH_W-1:0]       m_ch;
  logic                  core_start;
  logic [127:0]          core_key, core_iv;
  logic                  core_in_valid, core_in_ready, core_in_last;
  logic [127:0]          core_in_data;
  logic [15:0]           core_in_keep;
  logic                  core_out_valid, core_out_ready, core_out_last;
  logic [127:0]          core_out_data;
  logic [15:0]           core_out_keep;
  logic                  busy;
  logic [CH_W-1:0]       grant_ch;
  logic [1:0]            fsm_state;

  aes_ctr_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last), .m_ch(m_ch),
    .core_start(core_start), .core_key(core_key), .core_iv(core_iv),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_in_data(core_in_data), .core_in_keep(core_in_keep),
    .core_in_last(core_in_last),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .core_out_data(core_out_data), .core_out_keep(core_out_keep),
    .core_out_last(core_out_last),
    .busy(busy), .grant_ch(grant_ch), .fsm_state(fsm_state)
  );

  // ---------------- behavioural core ----------------
  function automatic logic [127:0] ks(input logic [127:0] k, input logic [127:0] c);
    return k ^ {c[63:0], c[127:64]};
  endfunction

  logic [127:0] sc_key, sc_ctr, ob_data;
  logic [15:0]  ob_keep;
  logic         ob_valid, ob_last;

  assign core_in_ready  = !ob_valid;
  assign core_out_valid = ob_valid;
  assign core_out_data  = ob_data;
  assign core_out_keep  = ob_keep;
  assign core_out_last  = ob_last;

  always @(posedge clk) begin
    if (rst) begin
      ob_valid <= 1'b0;
      ob_data  <= '0;
      ob_keep  <= '0;
      ob_last  <= 1'b0;
      sc_key   <= '0;
      sc_ctr   <= '0;
    end else begin
      if (core_start) begin
        sc_key <= core_key;
        sc_ctr <= core_iv;
      end
      if (ob_valid && core_out_ready) ob_valid <= 1'b0;
      if (core_in_valid && core_in_ready) begin
        ob_valid <= 1'b1;
        ob_data  <= core_in_data ^ ks(sc_key, sc_ctr);
        ob_keep  <= core_in_keep;
        ob_last  <= core_in_last;
        sc_ctr   <= sc_ctr + 128'd1;
      end
    end
  end

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } blk_t;

  blk_t         drv_q [NUM_CH][$];
  blk_t         mdl_q [NUM_CH][$];
  logic [EXP_W-1:0] exp_q[$];
  logic [LD_W-1:0]  ld_q[$];
  logic [127:0] ref_key [NUM_CH];
  logic [127:0] ref_ctr [NUM_CH];
  logic         ref_vld [NUM_CH];
  int           ref_rr;
  logic         m_ready_en;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      drv_q[c].delete();
      mdl_q[c].delete();
      ref_key[c] = '0;
      ref_ctr[c] = '0;
      ref_vld[c] = 1'b0;
    end
    exp_q.delete();
    ld_q.delete();
    ref_rr = 0;
  endtask

  // Serve pending packets in round-robin order among configured channels.
  task automatic model_schedule();
    int   pick;
    blk_t b;
    bit   done;
    forever begin
      pick = -1;
      for (int i = 0; i < NUM_CH; i++) begin
        int c = (ref_rr + i) % NUM_CH;
        if (pick < 0 && ref_vld[c] && mdl_q[c].size() > 0) pick = c;
      end
      if (pick < 0) break;
      ld_q.push_back({CH_W'(pick), ref_ctr[pick], ref_key[pick]});
      done = 0;
      while (!done && mdl_q[pick].size() > 0) begin
        b = mdl_q[pick].pop_front();
        exp_q.push_back({CH_W'(pick), b.keep, b.last, b.data ^ ks(ref_key[pick], ref_ctr[pick])});
        ref_ctr[pick] = ref_ctr[pick] + 128'd1;
        done = b.last;
      end
      ref_rr = (pick + 1) % NUM_CH;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_blk(input int c, input logic [127:0] d, input logic [15:0] k, input logic l);
    blk_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    drv_q[c].push_back(b);
    mdl_q[c].push_back(b);
  endtask

  task automatic send_pkt(input int c, input int nblk);
    for (int i = 0; i < nblk; i++) begin
      send_blk(c, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), (i == nblk - 1));
    end
  endtask

  task automatic cfg_write(input int c, input logic [127:0] k, input logic [127:0] iv, input logic accept);
    @(negedge clk);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(c);
    cfg_key = k;
    cfg_iv  = iv;
    #1;
    chk("cfg_ready", 272'(cfg_ready), 272'(accept));
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (accept) begin
      ref_key[c] = k;
      ref_ctr[c] = iv;
      ref_vld[c] = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int cyc = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy !== 1'b0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (cyc >= budget) begin
      n_err++;
      $display("FAIL %s: timeout with %0d results outstanding, busy=%b", name, exp_q.size(), busy);
    end
  endtask

  task automatic wait_sig(input int budget, input string name, input int which);
    int cyc = 0;
    @(negedge clk);
    while (((which == 0) ? busy !== 1'b1 : core_out_valid !== 1'b1) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (cyc >= budget) begin
      n_err++;
      $display("FAIL %s: timeout waiting, got 0 required 1", name);
    end
  endtask

  // Input stream driver: pops a block after each accepted beat.
  initial begin
    logic [NUM_CH-1:0] hs;
    s_valid = '0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = '0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (hs[c] && drv_q[c].size() > 0) drv_q[c].delete(0);
        if (drv_q[c].size() > 0) begin
          s_valid[c]           = 1'b1;
          s_data[c*128 +: 128] = drv_q[c][0].data;
          s_keep[c*16 +: 16]   = drv_q[c][0].keep;
          s_last[c]            = drv_q[c][0].last;
        end else begin
          s_valid[c] = 1'b0;
          s_last[c]  = 1'b0;
        end
      end
      m_ready = m_ready_en && ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    logic [LD_W-1:0]  l;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got ch=%0d data=%0h, none expected", m_ch, m_data);
          end else begin
            e = exp_q.pop_front();
            chk("m_result", 272'({m_ch, m_keep, m_last, m_data}), 272'(e));
          end
        end
        if (core_start) begin
          if (ld_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_load: got ch=%0d iv=%0h, none expected", grant_ch, core_iv);
          end else begin
            l = ld_q.pop_front();
            chk("core_load", 272'({grant_ch, core_iv, core_key}), 272'(l));
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int mask;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_key    = '0;
    cfg_iv     = '0;
    m_ready_en = 1'b1;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ctrl", 272'({cfg_ready, s_ready, busy, m_valid, core_start, core_in_valid,
                             core_out_ready, grant_ch, m_ch, fsm_state}),
        272'({1'b1, {NUM_CH{1'b0}}, 5'b0, {CH_W{1'b0}}, {CH_W{1'b0}}, 2'b0}));
    chk("reset_ctx", 272'({core_iv, core_key}), 272'(0));

    // Two-block packet on channel 0 with the reference key/IV.
    cfg_write(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 1'b1);
    send_blk(0, 128'h6bc1bee22e409f96e93d7e117393172a, 16'hffff, 1'b0);
    send_blk(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 16'hffff, 1'b1);
    model_schedule();
    wait_idle(200, "two_block");

    // All four channels, then all again, then channel 1 silent.
    for (int c = 1; c < NUM_CH; c++) cfg_write(c, {$urandom, $urandom, $urandom, $urandom},
                                               {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) send_pkt(c, 1);
      model_schedule();
      wait_idle(400, "rr_all");
    end
    @(negedge clk);
    send_pkt(0, 1);
    send_pkt(2, 1);
    send_pkt(3, 1);
    model_schedule();
    wait_idle(400, "rr_skip1");

    // Granted channel refuses a config write; another channel accepts one.
    m_ready_en = 1'b0;
    repeat (2) @(negedge clk);
    send_pkt(0, 4);
    model_schedule();
    wait_sig(50, "hold_busy", 0);
    cfg_write(0, 128'hdead, 128'hbeef, 1'b0);
    cfg_write(3, {$urandom, $urandom, $urandom, $urandom}, 128'h1000, 1'b1);
    m_ready_en = 1'b1;
    wait_idle(400, "hold_release");
    @(negedge clk);
    send_pkt(0, 2);
    send_pkt(3, 2);
    model_schedule();
    wait_idle(400, "after_cfg");

    // Counter wrap: second packet must load counter 0.
    cfg_write(1, {$urandom, $urandom, $urandom, $urandom}, {128{1'b1}}, 1'b1);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      send_pkt(1, 1);
      model_schedule();
      wait_idle(200, "ctr_wrap");
    end

    // Reset in the middle of a packet with the output stalled.
    m_ready_en = 1'b0;
    repeat (2) @(negedge clk);
    send_pkt(1, 3);
    model_schedule();
    wait_sig(50, "stall_out", 1);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("mid_reset", 272'({busy, m_valid, cfg_ready, s_ready, core_start}),
        272'({1'b0, 1'b0, 1'b1, {NUM_CH{1'b0}}, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    m_ready_en = 1'b1;
    for (int c = 0; c < NUM_CH; c++) send_pkt(c, 1);
    repeat (6) @(negedge clk);
    chk("no_ctx_no_grant", 272'({busy, s_ready}), 272'(0));

    // Channels 0,1,3 configured; channel 2 stays unconfigured.
    cfg_write(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    model_schedule();
    cfg_write(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    model_schedule();
    cfg_write(3, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    model_schedule();
    wait_idle(400, "unconfigured_skip");
    repeat (3) @(negedge clk);
    chk("ch2_waiting", 272'({busy, s_ready[2], s_valid[2]}), 272'(3'b001));
    cfg_write(2, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    model_schedule();
    @(posedge clk);
    #1;
    chk("ch2_granted", 272'({busy, grant_ch}), 272'({1'b1, CH_W'(2)}));
    wait_idle(200, "ch2_done");

    // Randomized batches.
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_write($urandom_range(0, NUM_CH - 1), {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      end
      @(negedge clk);
      mask = $urandom_range(1, (1 << NUM_CH) - 1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask[c]) begin
          for (int p = $urandom_range(1, 2); p > 0; p--) send_pkt(c, $urandom_range(1, 3));
        end
      end
      model_schedule();
      wait_idle(1000, "random_batch");
    end

    repeat (4) @(negedge clk);
    chk("queues_empty", 272'({32'(exp_q.size()), 32'(ld_q.size())}), 272'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
